// File: rtl/huffman_dec.sv
// huffman_dec: serial MSB-first decoder for a 6-symbol, up-to-5-bit code table.
// Ports: clk/reset, code_valid+HC1..HC6+M1..M6 load, bit_valid/bit_in/bit_last in, bit_ready/sym_valid/sym/sym_cnt/done/err out.
module huffman_dec (
  input  logic       clk,
  input  logic       reset,
  input  logic       code_valid,
  input  logic [7:0] HC1,
  input  logic [7:0] HC2,
  input  logic [7:0] HC3,
  input  logic [7:0] HC4,
  input  logic [7:0] HC5,
  input  logic [7:0] HC6,
  input  logic [7:0] M1,
  input  logic [7:0] M2,
  input  logic [7:0] M3,
  input  logic [7:0] M4,
  input  logic [7:0] M5,
  input  logic [7:0] M6,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       bit_last,
  output logic       bit_ready,
  output logic       sym_valid,
  output logic [2:0] sym,
  output logic [7:0] sym_cnt,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DEC  = 2'd1;
  localparam logic [1:0] S_ERR  = 2'd2;

  logic [1:0]      state;
  logic [5:0][7:0] hc_q;
  logic [5:0][7:0] m_q;
  logic [5:0][2:0] len;
  logic [7:0]      acc;
  logic [2:0]      n;
  logic [7:0]      nacc;
  logic [2:0]      nn;
  logic            hit;
  logic [2:0]      hit_sym;
  logic            accept;

  // Only exact 2^len-1 masks give a usable length.
  function automatic logic [2:0] mask_len(input logic [7:0] m);
    logic [2:0] l;
    case (m)
      8'h01:   l = 3'd1;
      8'h03:   l = 3'd2;
      8'h07:   l = 3'd3;
      8'h0F:   l = 3'd4;
      8'h1F:   l = 3'd5;
      default: l = 3'd0;
    endcase
    return l;
  endfunction

  always_comb begin
    for (int i = 0; i < 6; i++) begin
      len[i] = mask_len(m_q[i]);
    end
  end

  assign bit_ready = (state == S_DEC);
  assign accept    = bit_valid & bit_ready & ~code_valid;
  assign nacc      = {acc[6:0], bit_in};
  assign nn        = n + 3'd1;

  // Scan high to low so the lowest matching index wins.
  always_comb begin
    hit     = 1'b0;
    hit_sym = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (len[i] == nn && len[i] != 3'd0 &&
          (nacc & m_q[i]) == (hc_q[i] & m_q[i])) begin
        hit     = 1'b1;
        hit_sym = 3'(i + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      hc_q      <= '0;
      m_q       <= '0;
      acc       <= '0;
      n         <= '0;
      sym_valid <= 1'b0;
      sym       <= '0;
      sym_cnt   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      sym_valid <= 1'b0;
      done      <= 1'b0;
      if (code_valid) begin
        hc_q    <= {HC6, HC5, HC4, HC3, HC2, HC1};
        m_q     <= {M6, M5, M4, M3, M2, M1};
        acc     <= '0;
        n       <= '0;
        sym_cnt <= '0;
        err     <= 1'b0;
        state   <= S_DEC;
      end else if (accept) begin
        if (hit) begin
          sym_valid <= 1'b1;
          sym       <= hit_sym;
          sym_cnt   <= sym_cnt + 8'd1;
          acc       <= '0;
          n         <= '0;
          if (bit_last) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
        end else if (bit_last || nn == 3'd5) begin
          err   <= 1'b1;
          acc   <= '0;
          n     <= '0;
          state <= S_ERR;
        end else begin
          acc <= nacc;
          n   <= nn;
        end
      end
    end
  end

endmodule

// File: doc/huffman_dec.md
HUFFMAN_DEC -- requirements
Module: huffman_dec

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 reset  input  1  asynchronous, active-high reset.
REQ-003 code_valid  input  1  one-cycle strobe; HC1..HC6 and M1..M6 are valid this cycle.
REQ-004 HC1..HC6  input  8 each  code values for symbols 1..6; the code occupies the low len bits.
REQ-005 M1..M6  input  8 each  masks of the form 2^len-1, with len 0..5; M=0 marks the symbol unused.
REQ-006 bit_valid  input  1  a serial code bit is presented this cycle.
REQ-007 bit_in  input  1  serial code bit, sent MSB-first (bit len-1 of the code first).
REQ-008 bit_last  input  1  qualifies bit_valid; this is the final bit of the stream.
REQ-009 bit_ready  output  1  high while in DEC; bits are accepted only when bit_valid&bit_ready.
REQ-010 sym_valid  output  1  one-cycle pulse; sym holds a decoded symbol.
REQ-011 sym  output  3  decoded symbol, 1..6.
REQ-012 sym_cnt  output  8  number of symbols decoded since the table was loaded; wraps 255->0.
REQ-013 done  output  1  one-cycle pulse when the stream ends on a code boundary.
REQ-014 err  output  1  sticky decode error flag.

Function
REQ-015 The block SHALL have states IDLE, DEC, ERR.
- IDLE: no table loaded.
- DEC: decoding.
- ERR: error, waiting for a reload.
REQ-016 code_valid in any state SHALL, on that edge:
- latch all 12 table inputs;
- clear acc (8b), n (3b), sym_cnt and err;
- enter DEC. Any partially received code is aborted.
REQ-017 The latched length of symbol i SHALL be the number of ones in Mi (0..5), decoded from the mask pattern; any other mask value SHALL be treated as len 0.
REQ-018 bit_valid SHALL be ignored in IDLE and ERR, and on any cycle where code_valid is high.
REQ-019 On each accepted bit the block SHALL form:
- nacc = {acc[6:0],bit_in}
- nn = n+1
REQ-020 Symbol i SHALL match when its len equals nn, len != 0, and (nacc & Mi) == (HCi & Mi). When several symbols match, the lowest index SHALL win.
REQ-021 On a match, at the next edge:
- sym_valid=1, sym=i;
- sym_cnt increments;
- acc and n clear to 0.
Latency is 1 cycle from the accepting edge to sym_valid being visible.
REQ-022 With no match and nn<5: acc=nacc, n=nn, no output.
REQ-023 With no match and nn==5: err=1, enter ERR, and sym_valid stays 0.
REQ-024 Accepted bit with bit_last=1:
- with a match: sym_valid and done pulse on the same cycle, then IDLE;
- with no match: err=1 and enter ERR, with done=0.
REQ-025 In ERR, err SHALL hold 1 and bit_ready SHALL be 0 until reset or code_valid.
REQ-026 After done, the block SHALL enter IDLE. A new stream requires a new code_valid.
REQ-027 sym_valid and done SHALL be registered, and low on every cycle not specified above.
REQ-028 sym and sym_cnt SHALL hold their values between pulses.
REQ-029 Back-to-back bit_valid on every cycle SHALL be sustained with no bubbles; there is no backpressure while in DEC.

Reset
REQ-030 While reset is high the block SHALL be in IDLE with the following outputs and registers:
- outputs: bit_ready=0, sym_valid=0, sym=0, sym_cnt=0, done=0, err=0;
- table registers: all 0;
- internal: acc=0, n=0.
REQ-031 Reset asserted mid-stream SHALL discard the partial code and the table. After release the block SHALL ignore bits until code_valid.

Verification
The table T used below is:
- HC1..HC6 = 01,01,01,01,01,00
- M1..M6 = 01,03,07,0F,1F,1F
- codes: 1, 01, 001, 0001, 00001, 00000

REQ-032 Table load: load T, then stream 1,0,1,0,0,0,0,0(last).
- Required: sym 1,2,6 at 1 cycle after bits 1,3,8.
- Required: done together with sym 6; sym_cnt=3.
REQ-033 Every code: stream 1,01,001,0001,00001,00000 back-to-back.
- Required: sym 1..6 in order, no gaps beyond code length, sym_cnt=6.
REQ-034 Unused symbol: load T with M6=00, send 0,0,0,0,0.
- Required: err=1 after the 5th bit; bit_ready=0; no sym_valid.
- Then code_valid: err clears, bit_ready=1.
REQ-035 Truncated stream: with T, send 0,0(last).
- Required: err=1, done=0.
REQ-036 Reset and reload mid-stream: with T, send 0,0 then pulse reset.
- Required: all outputs 0 and bits ignored.
- Reload T and send 1(last): sym=1, done=1, sym_cnt=1.
REQ-037 Reload with bit: with T, send 0, then code_valid and bit_valid on the same cycle, then bits 1,(last)1.
- Required: the same-cycle bit is ignored, and the stream yields sym 1, sym 1 with done.
